mem_stage: RTL
==============

// Module: mem_stage
// PURPOSE
//  Memory-access pipeline stage sitting between the EX/MEM and MEM/WB registers. It performs loads and stores
//  over a byte-serial RAM port, one byte per grant, little-endian. It sign/zero-extends load results and forwards
//  writeback info (wd/wreg/wdata) to WB. Non-memory ops pass through with zero added latency.
//  It raises stall_req_o while an access is in flight.
// PARAMETERS
//  ADDR_W  32  width of mem_addr_o; byte address = (mem_addr_i + k) truncated to ADDR_W bits (wraps at 2^ADDR_W)
// PORTS
//  clk          in   1       clock, all state on rising edge
//  rst          in   1       asynchronous reset, active-low
//  wd_i         in   5       dest reg addr from EX/MEM
//  wreg_i       in   1       dest write enable from EX/MEM
//  wdata_i      in   32      ALU result; store data for SB/SH/SW
//  aluop_i      in   8       EX_LB/LH/LW/LBU/LHU/SB/SH/SW or MEM_NOP (defines.v codes)
//  mem_addr_i   in   32      effective byte address from EX
//  wd_o         out  5       dest reg addr to MEM/WB
//  wreg_o       out  1       dest write enable to MEM/WB
//  wdata_o      out  32      writeback data to MEM/WB
//  stall_req_o  out  1       stall request to pipeline control
//  mem_req_o    out  1       byte request valid (registered)
//  mem_we_o     out  1       1=write byte, 0=read byte (registered)
//  mem_addr_o   out  ADDR_W  byte address (registered)
//  mem_wdata_o  out  8       write byte (registered)
//  mem_gnt_i    in   1       request accepted this cycle
//  mem_rdata_i  in   8       read byte, valid exactly one cycle after a read grant
//  misalign_o   out  1       one-cycle misalign pulse (MEM_ALIGN_CHECK_EN only; else tied 0)
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE, byte cnt=0, load buffer=0, mem_req_o=0, mem_we_o=0, mem_addr_o=0,
//    mem_wdata_o=0, misalign_o=0. Combinational outputs follow the IDLE rules with aluop_i.
//  - n = 1 (B/BU), 2 (H/HU), 4 (W). Byte k uses address mem_addr_i+k and data bits [8k+7:8k].
//  - FSM states:
//    - IDLE: memory op on aluop_i -> stall_req_o=1 this cycle; next state REQ, cnt=0, request byte 0.
//      Non-memory op -> stall_req_o=0; wd_o/wreg_o/wdata_o = inputs.
//    - REQ: mem_req_o held with addr/we/wdata stable until mem_gnt_i. On grant with cnt<n-1: cnt++, next byte
//      issued the following cycle (back-to-back). Last byte granted: store -> DONE; load -> LAST.
//    - LAST: mem_req_o=0; capture final read byte -> DONE.
//    - Read bytes land in buffer byte cnt_prev the cycle after their grant, including while the next byte waits for grant.
//    - DONE: stall_req_o=0; outputs valid for one cycle, then -> IDLE. EX/MEM advances at this edge.
//  - stall_req_o=1 in IDLE(with mem op), REQ, LAST; 0 in DONE and IDLE(non-mem).
//  - While stall_req_o=1: wreg_o=0, wd_o=0, wdata_o=0, so WB never double-writes.
//  - Timing with grant always high: load stalls n+2 cycles, store stalls n+1 cycles. Each withheld grant adds 1.
//  - DONE load: wreg_o=wreg_i, wd_o=wd_i, wdata_o = buffer sign-extended (LB/LH) or zero-extended (LBU/LHU/LW).
//  - DONE store: wreg_o=0, wdata_o=0.
//  - Inputs must stay stable while stall_req_o=1 (EX/MEM register frozen). The stage does not re-sample them mid-access.
//  - wreg_i=1 with wd_i=0 on a load: access still performed, wreg_o forced 0.
//  - Reset mid-access: request dropped immediately, partial load discarded. Partial store bytes already granted
//    remain written (not rolled back).
// CONFIGURATION
//  - MEM_ALIGN_CHECK_EN defined:
//    - LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, is not issued.
//    - IDLE -> DONE directly; misalign_o=1 in that DONE cycle; wreg_o=0 (1 stall cycle).
//  - MEM_ALIGN_CHECK_EN undefined: misaligned accesses run byte-serially like aligned ones; misalign_o tied 0.
// TESTING
//  - LW addr 0x100, RAM 11 22 33 44, gnt=1 -> reqs 0x100..0x103 on consecutive cycles; stall 6 cycles;
//    DONE: wdata_o=0x44332211, wreg_o=1, wd_o=wd_i.
//  - LB addr 0x3, byte 0x80 -> wdata_o=0xFFFFFF80. LBU same -> 0x00000080. LH bytes 0x34,0x92 -> 0xFFFF9234.
//  - SH wdata_i=0x1234ABCD addr 0x10 -> writes (0x10,0xCD),(0x11,0xAB), mem_we_o=1; stall 3 cycles; wreg_o=0.
//  - LW with gnt low 3 cycles on byte 1 -> addr 0x101 held stable; stall 9 cycles; result unchanged 0x44332211.
//  - rst low after byte 1 of LW -> mem_req_o=0 at once, state IDLE. After release with ADD on aluop_i:
//    stall_req_o=0, wdata_o=wdata_i same cycle.
//  - MEM_ALIGN_CHECK_EN, LW addr 0x102 -> no mem_req_o; misalign_o 1 cycle; wreg_o=0. Without macro:
//    bytes 0x102..0x105 read.

Source files
------------

// File: rtl/mem_stage.sv
// Byte-serial load/store pipeline stage between EX/MEM and MEM/WB, little-endian.
// Optional macro MEM_ALIGN_CHECK_EN rejects misaligned halfword/word accesses with a misalign pulse.
module mem_stage #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        wd_i,
  input  logic              wreg_i,
  input  logic [31:0]       wdata_i,
  input  logic [7:0]        aluop_i,
  input  logic [31:0]       mem_addr_i,
  output logic [4:0]        wd_o,
  output logic              wreg_o,
  output logic [31:0]       wdata_o,
  output logic              stall_req_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [7:0]        mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic [7:0]        mem_rdata_i,
  output logic              misalign_o
);

  localparam logic [7:0] OP_LB  = 8'b1110_0000;
  localparam logic [7:0] OP_LH  = 8'b1110_0001;
  localparam logic [7:0] OP_LW  = 8'b1110_0011;
  localparam logic [7:0] OP_LBU = 8'b1110_0100;
  localparam logic [7:0] OP_LHU = 8'b1110_0101;
  localparam logic [7:0] OP_SB  = 8'b1110_1000;
  localparam logic [7:0] OP_SH  = 8'b1110_1001;
  localparam logic [7:0] OP_SW  = 8'b1110_1011;

  typedef enum logic [1:0] {IDLE, REQ, LAST, DONE} state_t;

  state_t      state;
  logic [1:0]  cnt;
  logic [1:0]  rd_idx;
  logic        rd_pend;
  logic [31:0] ld_buf;

  logic        is_load, is_store, is_signed, is_mem, misaligned;
  logic [1:0]  last_idx;
  logic [31:0] load_ext;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_signed = 1'b0;
    last_idx  = 2'd0;
    case (aluop_i)
      OP_LB:   begin is_load = 1'b1; is_signed = 1'b1; end
      OP_LBU:  is_load = 1'b1;
      OP_LH:   begin is_load = 1'b1; is_signed = 1'b1; last_idx = 2'd1; end
      OP_LHU:  begin is_load = 1'b1; last_idx = 2'd1; end
      OP_LW:   begin is_load = 1'b1; last_idx = 2'd3; end
      OP_SB:   is_store = 1'b1;
      OP_SH:   begin is_store = 1'b1; last_idx = 2'd1; end
      OP_SW:   begin is_store = 1'b1; last_idx = 2'd3; end
      default: ;
    endcase
    is_mem = is_load | is_store;
`ifdef MEM_ALIGN_CHECK_EN
    misaligned = ((last_idx == 2'd1) && mem_addr_i[0]) ||
                 ((last_idx == 2'd3) && (mem_addr_i[1:0] != 2'b00));
`else
    misaligned = 1'b0;
`endif
  end

  function automatic logic [ADDR_W-1:0] addr_at(input logic [1:0] k);
    return mem_addr_i[ADDR_W-1:0] + ADDR_W'(k);
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= 2'd0;
      rd_idx      <= 2'd0;
      rd_pend     <= 1'b0;
      ld_buf      <= 32'd0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= 8'd0;
    end else begin
      // A read byte arrives one cycle after its grant, independent of the request FSM.
      if (rd_pend) ld_buf[8*rd_idx +: 8] <= mem_rdata_i;
      rd_pend <= 1'b0;
      case (state)
        IDLE: begin
          if (is_mem && misaligned) begin
            state <= DONE;
          end else if (is_mem) begin
            state       <= REQ;
            cnt         <= 2'd0;
            mem_req_o   <= 1'b1;
            mem_we_o    <= is_store;
            mem_addr_o  <= addr_at(2'd0);
            mem_wdata_o <= wdata_i[7:0];
          end
        end
        REQ: begin
          if (mem_gnt_i) begin
            rd_pend <= ~mem_we_o;
            rd_idx  <= cnt;
            if (cnt != last_idx) begin
              cnt         <= cnt + 2'd1;
              mem_addr_o  <= addr_at(cnt + 2'd1);
              mem_wdata_o <= wdata_i[8*(cnt + 2'd1) +: 8];
            end else begin
              mem_req_o <= 1'b0;
              mem_we_o  <= 1'b0;
              state     <= mem_we_o ? DONE : LAST;
            end
          end
        end
        LAST:    state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) misalign_o <= 1'b0;
    else      misalign_o <= (state == IDLE) && is_mem && misaligned;
  end
`else
  assign misalign_o = 1'b0;
`endif

  always_comb begin
    case (last_idx)
      2'd0:    load_ext = is_signed ? {{24{ld_buf[7]}}, ld_buf[7:0]}   : {24'd0, ld_buf[7:0]};
      2'd1:    load_ext = is_signed ? {{16{ld_buf[15]}}, ld_buf[15:0]} : {16'd0, ld_buf[15:0]};
      default: load_ext = ld_buf;
    endcase
  end

  // Writeback info is suppressed while stalled so WB never commits an instruction twice.
  always_comb begin
    wd_o        = wd_i;
    wreg_o      = wreg_i;
    wdata_o     = wdata_i;
    stall_req_o = 1'b0;
    case (state)
      IDLE: begin
        if (is_mem) begin
          stall_req_o = 1'b1;
          wd_o        = 5'd0;
          wreg_o      = 1'b0;
          wdata_o     = 32'd0;
        end
      end
      REQ, LAST: begin
        stall_req_o = 1'b1;
        wd_o        = 5'd0;
        wreg_o      = 1'b0;
        wdata_o     = 32'd0;
      end
      default: begin
        if (is_load && !misalign_o) begin
          wreg_o  = wreg_i && (wd_i != 5'd0);
          wdata_o = load_ext;
        end else begin
          wreg_o  = 1'b0;
          wdata_o = 32'd0;
        end
      end
    endcase
  end

endmodule
